// File: rtl/spim_fifo_pkg.sv
// Shared sizing constants and helpers for the spim FIFOs.
// The register block and the shift engine both size their level fields from these.
package spim_fifo_pkg;

   localparam int SPIM_TXF_DEPTH = 16;
   localparam int SPIM_RXF_DEPTH = 16;
   localparam int SPIM_FIFO_DW   = 8;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b10,
      OP_POP  = 2'b01,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Collapses the accepted push/pop pair into one operation for the level update.
   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      fifo_op_e op;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_BOTH;
         default: op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/spim_fifo_ram.sv
// DW x DEPTH storage for spim_fifo: synchronous write, asynchronous read.
// Kept separate so it can be replaced by a distributed-RAM primitive.
module spim_fifo_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; the FIFO's empty flag qualifies the read data.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spim_fifo.sv
// Parametrised first-word-fall-through FIFO for the spim TX/RX data paths,
// with watermark flags, sticky overflow/underflow errors and a synchronous flush.
module spim_fifo
   import spim_fifo_pkg::*;
#(
   parameter int DW    = SPIM_FIFO_DW,
   parameter int DEPTH = SPIM_TXF_DEPTH,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   input  logic [AW:0]   thresh,
   output logic          thr_le,
   output logic          thr_ge,
   input  logic          err_clr,
   output logic          ovf,
   output logic          udf
);

   if (DEPTH != (1 << AW)) begin : g_bad_depth
      $error("spim_fifo: DEPTH must equal 1<<AW");
   end
   if (DW < 1 || DW > 32) begin : g_bad_dw
      $error("spim_fifo: DW must be in 1..32");
   end

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          r_ovf;
   logic          r_udf;

   logic          w_full;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_push_rej;
   logic          w_pop_rej;
   fifo_op_e      w_op;

   assign w_full  = (r_level == (AW+1)'(DEPTH));
   assign w_empty = (r_level == '0);

   // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
   // There is no bypass on empty, so a simultaneous pop there is rejected.
   assign w_push_ok  = wr_en & (~w_full | rd_en);
   assign w_pop_ok   = rd_en & ~w_empty;
   assign w_push_rej = wr_en & ~w_push_ok;
   assign w_pop_rej  = rd_en & w_empty;
   assign w_op       = fifo_op(w_push_ok, w_pop_ok);

   // Flush shares the reset state but leaves RAM alone; a new error beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else if (!clr_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case (w_op)
            OP_PUSH: r_level <= r_level + (AW+1)'(1);
            OP_POP:  r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
         if (w_push_rej) begin
            r_ovf <= 1'b1;
         end else if (err_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_pop_rej) begin
            r_udf <= 1'b1;
         end else if (err_clr) begin
            r_udf <= 1'b0;
         end
      end
   end

   spim_fifo_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push_ok & clr_n),
      .i_waddr (r_wptr),
      .i_wdata (wr_data),
      .i_raddr (r_rptr),
      .o_rdata (rd_data)
   );

   assign full   = w_full;
   assign empty  = w_empty;
   assign level  = r_level;
   assign thr_le = (r_level <= thresh);
   assign thr_ge = (r_level >= thresh);
   assign ovf    = r_ovf;
   assign udf    = r_udf;

endmodule

// File: tb/tb_spim_fifo.sv
// Directed self-checking bench for spim_fifo at DW=8, DEPTH=16.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_spim_fifo;

   logic       clk;
   logic       rst_n;
   logic       clr_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic [4:0] thresh;
   logic       thr_le;
   logic       thr_ge;
   logic       err_clr;
   logic       ovf;
   logic       udf;

   int nVec = 0;
   int nMis = 0;

   spim_fifo #(
      .DW    (8),
      .DEPTH (16),
      .AW    (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_n   (clr_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .thresh  (thresh),
      .thr_le  (thr_le),
      .thr_ge  (thr_ge),
      .err_clr (err_clr),
      .ovf     (ovf),
      .udf     (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Status bundle {full, empty, ovf, udf, level} used by most comparisons.
   function automatic logic [8:0] status();
      return {full, empty, ovf, udf, level};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      clr_n   = 1'b1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      thresh  = 5'd0;
      wr_data = 8'h00;
      idle();
      tick();
      tick();
      nVec++;
      if (status() !== 9'b0_1_0_0_00000) begin
         nMis++;
         $display("[TB] FAIL reset_status: got %b want %b", status(), 9'b0_1_0_0_00000);
      end
      nVec++;
      if ({thr_le, thr_ge} !== 2'b11) begin
         nMis++;
         $display("[TB] FAIL reset_thr: got %b want 11", {thr_le, thr_ge});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) push(8'(i));
      nVec++;
      if (status() !== 9'b1_0_0_0_10000) begin
         nMis++;
         $display("[TB] FAIL fill_status: got %b want %b", status(), 9'b1_0_0_0_10000);
      end
      for (int i = 1; i <= 16; i++) begin
         nVec++;
         if (rd_data !== 8'(i)) begin
            nMis++;
            $display("[TB] FAIL drain_data[%0d]: got %h want %h", i, rd_data, 8'(i));
         end
         pop();
      end
      nVec++;
      if (status() !== 9'b0_1_0_0_00000) begin
         nMis++;
         $display("[TB] FAIL drain_status: got %b want %b", status(), 9'b0_1_0_0_00000);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 16; i++) push(8'(8'h20 + i));
      push(8'hAA);
      nVec++;
      if (status() !== 9'b1_0_1_0_10000) begin
         nMis++;
         $display("[TB] FAIL ovf_set: got %b want %b", status(), 9'b1_0_1_0_10000);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      nVec++;
      if (status() !== 9'b1_0_0_0_10000) begin
         nMis++;
         $display("[TB] FAIL ovf_clear: got %b want %b", status(), 9'b1_0_0_0_10000);
      end
      for (int i = 1; i <= 16; i++) begin
         nVec++;
         if (rd_data !== 8'(8'h20 + i)) begin
            nMis++;
            $display("[TB] FAIL ovf_drain[%0d]: got %h want %h", i, rd_data, 8'(8'h20 + i));
         end
         pop();
      end
      pop();
      nVec++;
      if (status() !== 9'b0_1_0_1_00000) begin
         nMis++;
         $display("[TB] FAIL udf_set: got %b want %b", status(), 9'b0_1_0_1_00000);
      end
      rd_en   = 1'b1;
      err_clr = 1'b1;
      tick();
      rd_en   = 1'b0;
      nVec++;
      if (udf !== 1'b1) begin
         nMis++;
         $display("[TB] FAIL udf_err_wins: got %b want 1", udf);
      end
      tick();
      err_clr = 1'b0;
      nVec++;
      if (udf !== 1'b0) begin
         nMis++;
         $display("[TB] FAIL udf_clear: got %b want 0", udf);
      end
   endtask

   task automatic test_full_pushpop();
      for (int i = 1; i <= 16; i++) push(8'(i));
      nVec++;
      if (rd_data !== 8'h01) begin
         nMis++;
         $display("[TB] FAIL fullpp_head: got %h want 01", rd_data);
      end
      wr_en   = 1'b1;
      wr_data = 8'h55;
      rd_en   = 1'b1;
      tick();
      idle();
      nVec++;
      if (status() !== 9'b1_0_0_0_10000) begin
         nMis++;
         $display("[TB] FAIL fullpp_status: got %b want %b", status(), 9'b1_0_0_0_10000);
      end
      for (int i = 2; i <= 16; i++) begin
         nVec++;
         if (rd_data !== 8'(i)) begin
            nMis++;
            $display("[TB] FAIL fullpp_drain[%0d]: got %h want %h", i, rd_data, 8'(i));
         end
         pop();
      end
      nVec++;
      if ({rd_data, level} !== {8'h55, 5'd1}) begin
         nMis++;
         $display("[TB] FAIL fullpp_tail: got %h/%0d want 55/1", rd_data, level);
      end
      pop();
   endtask

   task automatic test_empty_pushpop();
      wr_en   = 1'b1;
      wr_data = 8'h77;
      rd_en   = 1'b1;
      tick();
      idle();
      nVec++;
      if (status() !== 9'b0_0_0_1_00001) begin
         nMis++;
         $display("[TB] FAIL emptypp_status: got %b want %b", status(), 9'b0_0_0_1_00001);
      end
      nVec++;
      if (rd_data !== 8'h77) begin
         nMis++;
         $display("[TB] FAIL emptypp_data: got %h want 77", rd_data);
      end
      pop();
      nVec++;
      if (status() !== 9'b0_1_0_1_00000) begin
         nMis++;
         $display("[TB] FAIL emptypp_pop: got %b want %b", status(), 9'b0_1_0_1_00000);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_thresholds();
      logic [1:0] expThr [3];
      expThr[0] = 2'b10;
      expThr[1] = 2'b11;
      expThr[2] = 2'b01;
      thresh = 5'd4;
      push(8'h01);
      push(8'h02);
      for (int i = 0; i < 3; i++) begin
         push(8'(8'h03 + i));
         nVec++;
         if ({thr_le, thr_ge} !== expThr[i]) begin
            nMis++;
            $display("[TB] FAIL thr_lvl%0d: got %b want %b", 3 + i, {thr_le, thr_ge}, expThr[i]);
         end
      end
      for (int i = 0; i < 11; i++) push(8'(8'h10 + i));
      thresh = 5'd17;
      #1;
      nVec++;
      if ({thr_le, thr_ge, level} !== {2'b10, 5'd16}) begin
         nMis++;
         $display("[TB] FAIL thr_over_depth: got %b/%0d want 10/16", {thr_le, thr_ge}, level);
      end
      thresh = 5'd16;
      #1;
      nVec++;
      if ({thr_le, thr_ge} !== 2'b11) begin
         nMis++;
         $display("[TB] FAIL thr_eq_depth: got %b want 11", {thr_le, thr_ge});
      end
      thresh = 5'd0;
      clr_n  = 1'b0;
      tick();
      clr_n  = 1'b1;
      nVec++;
      if ({status(), thr_le, thr_ge} !== {9'b0_1_0_0_00000, 2'b11}) begin
         nMis++;
         $display("[TB] FAIL thr_flush: got %b want %b", {status(), thr_le, thr_ge}, {9'b0_1_0_0_00000, 2'b11});
      end
   endtask

   task automatic test_flush_wrap();
      pop();
      for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
      nVec++;
      if (status() !== 9'b0_0_0_1_01010) begin
         nMis++;
         $display("[TB] FAIL flush_pre: got %b want %b", status(), 9'b0_0_0_1_01010);
      end
      clr_n   = 1'b0;
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      tick();
      idle();
      nVec++;
      if (status() !== 9'b0_1_0_0_00000) begin
         nMis++;
         $display("[TB] FAIL flush_post: got %b want %b", status(), 9'b0_1_0_0_00000);
      end
      push(8'hA0);
      push(8'hA1);
      push(8'hA2);
      for (int i = 0; i < 40; i++) begin
         nVec++;
         if (rd_data !== 8'(8'hA0 + i)) begin
            nMis++;
            $display("[TB] FAIL wrap_head[%0d]: got %h want %h", i, rd_data, 8'(8'hA0 + i));
         end
         wr_en   = 1'b1;
         wr_data = 8'(8'hA3 + i);
         rd_en   = 1'b1;
         tick();
         idle();
      end
      nVec++;
      if (status() !== 9'b0_0_0_0_00011) begin
         nMis++;
         $display("[TB] FAIL wrap_level: got %b want %b", status(), 9'b0_0_0_0_00011);
      end
      for (int i = 40; i < 43; i++) begin
         nVec++;
         if (rd_data !== 8'(8'hA0 + i)) begin
            nMis++;
            $display("[TB] FAIL wrap_tail[%0d]: got %h want %h", i, rd_data, 8'(8'hA0 + i));
         end
         pop();
      end
      nVec++;
      if (status() !== 9'b0_1_0_0_00000) begin
         nMis++;
         $display("[TB] FAIL wrap_empty: got %b want %b", status(), 9'b0_1_0_0_00000);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_pushpop();
      test_empty_pushpop();
      test_thresholds();
      test_flush_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
